eth_crc32_stream: RTL and testbench

- Parametrised Ethernet CRC-32 engine with a streaming data path. Generalises the byte-wide CRC generator to DATA_W-bit beats with byte-lane keep.
- Has a registered valid/ready pass-through and an optional FCS-append state machine.
- Checks the receive-side residue on every frame.
- Sits between the MAC frame builder/parser and the PHY byte interface.

---
 rtl/eth_crc32_stream.sv | 147 ++++++++++++++
 tb/tb_eth_crc32_stream.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_crc32_stream.sv
// Streaming IEEE 802.3 CRC-32 engine: registered valid/ready slice, byte-lane keep,
// optional FCS append after each frame and receive-side residue check.
module eth_crc32_stream #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  crc_clr,
  input  logic                  append_en,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic [DATA_W/8-1:0]   s_keep,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_W-1:0]     m_data,
  output logic [DATA_W/8-1:0]   m_keep,
  output logic                  m_last,
  output logic [31:0]           crc_value,
  output logic                  crc_done,
  output logic                  crc_ok
);

  localparam int          KEEP_W   = DATA_W / 8;
  localparam int          NB       = (4 + KEEP_W - 1) / KEEP_W;
  localparam logic [1:0]  LAST_FCS = 2'(NB - 1);
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] RESIDUE  = 32'hDEBB_20E3;
  localparam logic [31:0] POLY     = 32'hEDB8_8320;

  typedef enum logic {ST_DATA, ST_FCS} state_t;

  // Lanes are folded in wire order (lane 0 first), each byte LSB first.
  function automatic logic [31:0] crc_beat(input logic [31:0]       crc_in,
                                           input logic [DATA_W-1:0] data,
                                           input logic [KEEP_W-1:0] keep);
    logic [31:0] c;
    c = crc_in;
    for (int l = 0; l < KEEP_W; l++) begin
      if (keep[l]) begin
        for (int b = 0; b < 8; b++) begin
          c = (c >> 1) ^ ((c[0] ^ data[8*l+b]) ? POLY : 32'h0);
        end
      end
    end
    return c;
  endfunction

  state_t              state, state_next;
  logic [31:0]         crc_reg, crc_next;
  logic                sof, append_latched, append_eff;
  logic [1:0]          fcs_idx;
  logic [3:0][7:0]     fcs_bytes;
  logic [DATA_W-1:0]   fcs_data;
  logic [KEEP_W-1:0]   fcs_keep;
  logic                slot_free, s_fire, m_fire, fcs_load, fcs_final;

  assign slot_free  = !m_valid || m_ready;
  assign s_ready    = (state == ST_DATA) && slot_free;
  assign s_fire     = s_valid && s_ready;
  assign m_fire     = m_valid && m_ready;
  assign fcs_load   = (state == ST_FCS) && slot_free;
  assign fcs_final  = (fcs_idx == LAST_FCS);
  assign append_eff = sof ? append_en : append_latched;
  assign crc_next   = crc_beat(crc_reg, s_data, s_keep);
  // crc_value already holds this frame's FCS by the time the FCS state is entered.
  assign fcs_bytes  = crc_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_DATA;
    else        state <= state_next;
  end

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    int b;
    state_next = state;
    fcs_data   = '0;
    fcs_keep   = '0;
    for (int l = 0; l < KEEP_W; l++) begin
      b = int'(fcs_idx) * KEEP_W + l;
      if (b < 4) begin
        fcs_data[8*l +: 8] = fcs_bytes[b[1:0]];
        fcs_keep[l]        = 1'b1;
      end
    end
    case (state)
      ST_DATA: if (s_fire && s_last && append_eff) state_next = ST_FCS;
      ST_FCS:  if (fcs_load && fcs_final)          state_next = ST_DATA;
      default: state_next = ST_DATA;
    endcase
    if (crc_clr) state_next = ST_DATA;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_reg        <= CRC_INIT;
      sof            <= 1'b1;
      append_latched <= 1'b0;
      fcs_idx        <= '0;
      m_valid        <= 1'b0;
      m_data         <= '0;
      m_keep         <= '0;
      m_last         <= 1'b0;
      crc_value      <= '0;
      crc_done       <= 1'b0;
      crc_ok         <= 1'b0;
    end else if (crc_clr) begin
      crc_reg        <= CRC_INIT;
      sof            <= 1'b1;
      append_latched <= 1'b0;
      fcs_idx        <= '0;
      m_valid        <= 1'b0;
      crc_done       <= 1'b0;
    end else begin
      crc_done <= 1'b0;
      if (s_fire) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_keep  <= s_keep;
        m_last  <= s_last && !append_eff;
        if (sof) append_latched <= append_en;
        if (s_last) begin
          crc_done  <= 1'b1;
          crc_value <= ~crc_next;
          crc_ok    <= (crc_next == RESIDUE);
          crc_reg   <= CRC_INIT;
          sof       <= 1'b1;
        end else begin
          crc_reg <= crc_next;
          sof     <= 1'b0;
        end
      end else if (fcs_load) begin
        m_valid <= 1'b1;
        m_data  <= fcs_data;
        m_keep  <= fcs_keep;
        m_last  <= fcs_final;
        fcs_idx <= fcs_final ? 2'd0 : fcs_idx + 2'd1;
      end else if (m_fire) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_crc32_stream.sv
// Scoreboard bench for eth_crc32_stream: one 8-bit and one 32-bit instance, expected
// beats and frame results queued at drive time and compared as the DUTs emit them.
module tb_eth_crc32_stream;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [31:0] crc;
    logic        ok;
  } done_t;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst_n;

  logic        clr8, app8, s_valid8, s_ready8, s_last8, m_valid8, m_ready8, m_last8;
  logic [7:0]  s_data8, m_data8;
  logic [0:0]  s_keep8, m_keep8;
  logic [31:0] crc_value8;
  logic        crc_done8, crc_ok8;

  logic        clr32, app32, s_valid32, s_ready32, s_last32, m_valid32, m_ready32, m_last32;
  logic [31:0] s_data32, m_data32;
  logic [3:0]  s_keep32, m_keep32;
  logic [31:0] crc_value32;
  logic        crc_done32, crc_ok32;

  int checks   = 0;
  int failures = 0;
  bit rnd32    = 1'b0;

  beat_t exp8_q[$], exp32_q[$];
  done_t done8_q[$], done32_q[$];

  always #5 clk = ~clk;

  eth_crc32_stream #(.DATA_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .crc_clr(clr8), .append_en(app8),
    .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data8), .s_keep(s_keep8), .s_last(s_last8),
    .m_valid(m_valid8), .m_ready(m_ready8), .m_data(m_data8), .m_keep(m_keep8), .m_last(m_last8),
    .crc_value(crc_value8), .crc_done(crc_done8), .crc_ok(crc_ok8)
  );

  eth_crc32_stream #(.DATA_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .crc_clr(clr32), .append_en(app32),
    .s_valid(s_valid32), .s_ready(s_ready32), .s_data(s_data32), .s_keep(s_keep32), .s_last(s_last32),
    .m_valid(m_valid32), .m_ready(m_ready32), .m_data(m_data32), .m_keep(m_keep32), .m_last(m_last32),
    .crc_value(crc_value32), .crc_done(crc_done32), .crc_ok(crc_ok32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte-at-a-time reference register (reflected form), independent of lane layout.
  function automatic logic [31:0] ref_crc(input byte_q_t bytes);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (bytes[i]) begin
      c ^= {24'h0, bytes[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  always @(posedge clk) begin
    #1;
    m_ready8  = 1'b1;
    m_ready32 = rnd32 ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  beat_t e8, e32, held32;
  done_t d8, d32;
  bit    stall32 = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid8 && m_ready8) begin
        if (exp8_q.size() == 0) check("extra_beat8", 64'(1), 64'(0));
        else begin
          e8 = exp8_q.pop_front();
          check("data8", 64'(m_data8), 64'(e8.data[7:0]));
          check("keep8", 64'(m_keep8), 64'(e8.keep[0]));
          check("last8", 64'(m_last8), 64'(e8.last));
        end
      end
      if (crc_done8) begin
        if (done8_q.size() == 0) check("extra_done8", 64'(1), 64'(0));
        else begin
          d8 = done8_q.pop_front();
          check("crc_value8", 64'(crc_value8), 64'(d8.crc));
          check("crc_ok8", 64'(crc_ok8), 64'(d8.ok));
        end
      end
      if (stall32) begin
        check("stall_valid32", 64'(m_valid32), 64'(1));
        check("stall_beat32", 64'({m_data32, m_keep32, m_last32}), 64'(held32));
      end
      if (m_valid32 && m_ready32) begin
        if (exp32_q.size() == 0) check("extra_beat32", 64'(1), 64'(0));
        else begin
          e32 = exp32_q.pop_front();
          check("data32", 64'(m_data32), 64'(e32.data));
          check("keep32", 64'(m_keep32), 64'(e32.keep));
          check("last32", 64'(m_last32), 64'(e32.last));
        end
      end
      stall32 = m_valid32 && !m_ready32;
      held32  = '{data: m_data32, keep: m_keep32, last: m_last32};
      if (crc_done32) begin
        if (done32_q.size() == 0) check("extra_done32", 64'(1), 64'(0));
        else begin
          d32 = done32_q.pop_front();
          check("crc_value32", 64'(crc_value32), 64'(d32.crc));
          check("crc_ok32", 64'(crc_ok32), 64'(d32.ok));
        end
      end
    end else begin
      stall32 = 1'b0;
    end
  end

  task automatic send_beat(input bit w32, input logic [31:0] d, input logic [3:0] k,
                           input bit last, input bit app);
    bit acc;
    int t;
    if (w32) begin
      if (rnd32) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      s_valid32 = 1'b1; s_data32 = d; s_keep32 = k; s_last32 = last; app32 = app;
      exp32_q.push_back('{data: d, keep: k, last: last && !app});
    end else begin
      s_valid8 = 1'b1; s_data8 = d[7:0]; s_keep8 = k[0]; s_last8 = last; app8 = app;
      exp8_q.push_back('{data: d, keep: k, last: last && !app});
    end
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = w32 ? s_ready32 : s_ready8;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) check("send_timeout", 64'(0), 64'(1));
    if (w32) s_valid32 = 1'b0;
    else     s_valid8  = 1'b0;
  endtask

  task automatic send_frame(input bit w32, input byte_q_t bytes, input bit app);
    int          n, w;
    logic [31:0] d, reg_end, fcs;
    logic [3:0]  k;
    n = bytes.size();
    w = w32 ? 4 : 1;
    for (int i = 0; i < n; i += w) begin
      d = '0;
      k = '0;
      for (int j = 0; j < w; j++) begin
        if (i + j < n) begin
          d[8*j +: 8] = bytes[i+j];
          k[j]        = 1'b1;
        end
      end
      send_beat(w32, d, k, (i + w >= n), app);
    end
    reg_end = ref_crc(bytes);
    fcs     = ~reg_end;
    if (w32) done32_q.push_back('{crc: fcs, ok: reg_end == 32'hDEBB_20E3});
    else     done8_q.push_back('{crc: fcs, ok: reg_end == 32'hDEBB_20E3});
    if (app) begin
      if (w32) exp32_q.push_back('{data: fcs, keep: 4'hF, last: 1'b1});
      else for (int b = 0; b < 4; b++)
        exp8_q.push_back('{data: {24'h0, fcs[8*b +: 8]}, keep: 4'h1, last: b == 3});
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp8_q.size() + exp32_q.size() + done8_q.size() + done32_q.size()) != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    check("drain_timeout", 64'(t < 1000), 64'(1));
    repeat (3) @(posedge clk);
    #1;
  endtask

  byte_q_t msg, frame, rnd_frame;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {clr8, app8, s_valid8, s_last8, clr32, app32, s_valid32, s_last32} = '0;
    s_data8 = '0; s_keep8 = '0; s_data32 = '0; s_keep32 = '0;
    for (int i = 1; i <= 9; i++) msg.push_back(8'(8'h30 + i));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", 64'(m_valid8), 64'(0));
    check("rst_m_data", 64'(m_data32), 64'(0));
    check("rst_m_keep", 64'(m_keep32), 64'(0));
    check("rst_m_last", 64'(m_last8), 64'(0));
    check("rst_crc_value", 64'(crc_value32), 64'(0));
    check("rst_crc_done", 64'(crc_done8), 64'(0));
    check("rst_crc_ok", 64'(crc_ok8), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte-wide append of "123456789".
    send_frame(1'b0, msg, 1'b1);
    drain();
    check("t1_crc_value", 64'(crc_value8), 64'(32'hCBF4_3926));

    // Receive residue: good frame then single-bit corruption.
    frame = msg;
    frame.push_back(8'h26); frame.push_back(8'h39); frame.push_back(8'hF4); frame.push_back(8'hCB);
    send_frame(1'b0, frame, 1'b0);
    drain();
    check("t2_ok_good", 64'(crc_ok8), 64'(1));
    frame[3] = frame[3] ^ 8'h01;
    send_frame(1'b0, frame, 1'b0);
    drain();
    check("t2_ok_bad", 64'(crc_ok8), 64'(0));

    // 32-bit lanes with a partial last beat.
    send_frame(1'b1, msg, 1'b1);
    drain();
    check("t3_crc_value", 64'(crc_value32), 64'(32'hCBF4_3926));

    // Random back-pressure and gaps over several frame lengths, both modes.
    rnd32 = 1'b1;
    send_frame(1'b1, msg, 1'b1);
    foreach (msg[n]) begin
      rnd_frame.delete();
      for (int i = 0; i <= n; i++) rnd_frame.push_back(8'($urandom));
      send_frame(1'b1, rnd_frame, 1'($urandom_range(0, 1)));
    end
    send_frame(1'b1, frame, 1'b0);
    send_frame(1'b1, msg, 1'b1);
    drain();
    rnd32 = 1'b0;
    drain();
    check("t4_crc_value", 64'(crc_value32), 64'(32'hCBF4_3926));

    // Abort after five bytes; the aborted frame must not complete.
    for (int i = 0; i < 5; i++) send_beat(1'b0, {24'h0, msg[i]}, 4'h1, 1'b0, 1'b1);
    clr8 = 1'b1;
    @(posedge clk); #1;
    clr8 = 1'b0;
    send_frame(1'b0, msg, 1'b1);
    drain();
    check("t5_crc_value", 64'(crc_value8), 64'(32'hCBF4_3926));

    // Async reset while FCS bytes are being emitted.
    send_frame(1'b0, msg, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    exp8_q.delete();
    done8_q.delete();
    check("t6_m_valid", 64'(m_valid8), 64'(0));
    check("t6_m_last", 64'(m_last8), 64'(0));
    check("t6_m_data", 64'(m_data8), 64'(0));
    check("t6_crc_value", 64'(crc_value8), 64'(0));
    check("t6_crc_ok", 64'(crc_ok8), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(1'b0, msg, 1'b1);
    drain();
    check("t6_after_crc", 64'(crc_value8), 64'(32'hCBF4_3926));

    check("q8_empty", 64'(exp8_q.size()), 64'(0));
    check("q32_empty", 64'(exp32_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
